// File: rtl/riscv_dmem_pkg.sv
// riscv_dmem_pkg: shared encodings for the data-memory responder.
//   - memop_e      : core memaccess op encodings (none/load, SB, SH, SW)
//   - REGION_*     : mem_addr[31:28] region selectors
//   - MMIO_*       : MMIO register offsets within the MMIO region
//   - ST_*         : STATUS register bit positions
//   - rotr_bytes() : byte-granular right rotation used on the load path
package riscv_dmem_pkg;

  typedef enum logic [1:0] {
    MEMOP_NONE = 2'b00,
    MEMOP_SB   = 2'b01,
    MEMOP_SH   = 2'b10,
    MEMOP_SW   = 2'b11
  } memop_e;

  localparam logic [3:0] REGION_RAM  = 4'h0;
  localparam logic [3:0] REGION_MMIO = 4'hF;

  localparam logic [27:0] MMIO_CONSOLE = 28'h000_0000;
  localparam logic [27:0] MMIO_STATUS  = 28'h000_0004;
  localparam logic [27:0] MMIO_CYCLE   = 28'h000_0008;

  localparam int unsigned ST_FULL      = 0;
  localparam int unsigned ST_EMPTY     = 1;
  localparam int unsigned ST_OVERFLOW  = 2;
  localparam int unsigned ST_MISALIGN  = 3;
  localparam int unsigned ST_COUNT_LSB = 4;
  localparam int unsigned ST_COUNT_W   = 5;

  function automatic logic [31:0] rotr_bytes(input logic [31:0] w, input logic [1:0] sh);
    logic [31:0] r;
    case (sh)
      2'd0:    r = w;
      2'd1:    r = {w[7:0],  w[31:8]};
      2'd2:    r = {w[15:0], w[31:16]};
      default: r = {w[23:0], w[31:24]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_dmem_fifo.sv
// riscv_dmem_fifo: console byte FIFO, power-of-two depth, synchronous reset.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_push, i_data     : push request and byte
//   i_pop              : pop request (ignored while empty)
//   o_full, o_empty    : occupancy flags
//   o_count            : entries held, 0..DEPTH
//   o_head             : head entry, 0 while empty
//   o_drop             : push request rejected this cycle (full, no pop)
module riscv_dmem_fifo
  import riscv_dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_drop
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rd];

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted when paired with a pop.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);
  assign o_drop = i_push & o_full & ~w_pop;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/riscv_dmem.sv
// riscv_dmem: data-memory responder for a single-cycle core.
//   Word RAM with byte-lane stores plus an MMIO page (console TX FIFO,
//   STATUS, CYCLE). Loads are combinational; stores commit at the clk edge.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   mem_op          : 00 none/load, 01 SB, 10 SH, 11 SW
//   mem_addr        : byte address
//   mem_store_data  : unshifted store data
//   mem_load_data   : addressed word rotated so the addressed byte is at bit 0
//   tx_valid/tx_ready/tx_data : console byte stream
//   misalign        : sticky, misaligned SH/SW seen
//   overflow        : sticky, console push dropped
// Build option: define RISCV_DMEM_CONSOLE_EN to include the console FIFO.
module riscv_dmem
  import riscv_dmem_pkg::*;
#(
  parameter int unsigned RAM_AW     = 10,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_store_data,
  output logic [31:0] mem_load_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        misalign,
  output logic        overflow
);

  logic [31:0]       r_ram [2**RAM_AW];
  logic [31:0]       r_cycle;
  logic              r_misalign;

  memop_e            w_op;
  logic [3:0]        w_region;
  logic [27:0]       w_off;
  logic [RAM_AW-1:0] w_idx;
  logic              w_misal;
  logic              w_store;
  logic              w_ram_we;
  logic              w_push;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_word;
  logic [31:0]       w_status;
  logic              w_full;
  logic              w_empty;
  logic              w_overflow;
  logic [4:0]        w_count;

  assign w_op     = memop_e'(mem_op);
  assign w_region = mem_addr[31:28];
  assign w_off    = {mem_addr[27:2], 2'b00};
  assign w_idx    = mem_addr[RAM_AW+1:2];

  assign w_misal  = ((w_op == MEMOP_SH) & mem_addr[0]) |
                    ((w_op == MEMOP_SW) & (mem_addr[1:0] != 2'b00));
  assign w_store  = (w_op != MEMOP_NONE) & ~w_misal;
  assign w_ram_we = w_store & (w_region == REGION_RAM);
  assign w_push   = w_store & (w_region == REGION_MMIO) & (w_off == MMIO_CONSOLE);

  // Data is replicated across lanes so each enabled lane picks its own copy.
  always_comb begin
    w_be    = '0;
    w_wdata = '0;
    case (w_op)
      MEMOP_SB: begin
        w_be    = 4'b0001 << mem_addr[1:0];
        w_wdata = {4{mem_store_data[7:0]}};
      end
      MEMOP_SH: begin
        w_be    = mem_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{mem_store_data[15:0]}};
      end
      MEMOP_SW: begin
        w_be    = 4'b1111;
        w_wdata = mem_store_data;
      end
      default: begin
        w_be    = '0;
        w_wdata = '0;
      end
    endcase
  end

  // RAM is not reset; a store during rst still commits.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_ram[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle    <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_cycle    <= r_cycle + 32'd1;
      r_misalign <= r_misalign | w_misal;
    end
  end

`ifdef RISCV_DMEM_CONSOLE_EN
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
  logic                        w_drop;
  logic                        r_overflow;

  riscv_dmem_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_data  (mem_store_data[7:0]),
    .i_pop   (tx_ready),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count),
    .o_head  (tx_data),
    .o_drop  (w_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) r_overflow <= 1'b0;
    else     r_overflow <= r_overflow | w_drop;
  end

  assign tx_valid   = ~w_empty;
  assign w_overflow = r_overflow;
  assign w_count    = 5'(w_fifo_count);
`else
  logic w_unused_console;
  assign w_unused_console = tx_ready | w_push;
  assign tx_valid   = 1'b0;
  assign tx_data    = '0;
  assign w_full     = 1'b0;
  assign w_empty    = 1'b1;
  assign w_overflow = 1'b0;
  assign w_count    = '0;
`endif

  assign overflow = w_overflow;
  assign misalign = r_misalign;

  always_comb begin
    w_status                              = '0;
    w_status[ST_FULL]                     = w_full;
    w_status[ST_EMPTY]                    = w_empty;
    w_status[ST_OVERFLOW]                 = w_overflow;
    w_status[ST_MISALIGN]                 = r_misalign;
    w_status[ST_COUNT_LSB +: ST_COUNT_W]  = w_count;
  end

  always_comb begin
    w_word = '0;
    if (w_region == REGION_RAM) begin
      w_word = r_ram[w_idx];
    end else if (w_region == REGION_MMIO) begin
      if (w_off == MMIO_STATUS)     w_word = w_status;
      else if (w_off == MMIO_CYCLE) w_word = r_cycle;
      else                          w_word = '0;
    end
  end

  assign mem_load_data = rotr_bytes(w_word, mem_addr[1:0]);

endmodule

// File: tb/tb_riscv_dmem.sv
module tb_riscv_dmem;

  localparam logic [1:0]  OP_NONE = 2'b00;
  localparam logic [1:0]  OP_SB   = 2'b01;
  localparam logic [1:0]  OP_SH   = 2'b10;
  localparam logic [1:0]  OP_SW   = 2'b11;
  localparam logic [31:0] A_CONS  = 32'hF000_0000;
  localparam logic [31:0] A_STAT  = 32'hF000_0004;
  localparam logic [31:0] A_CYC   = 32'hF000_0008;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_store_data;
  logic [31:0] mem_load_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        misalign;
  logic        overflow;

  riscv_dmem #(
    .RAM_AW     (10),
    .FIFO_DEPTH (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_op         (mem_op),
    .mem_addr       (mem_addr),
    .mem_store_data (mem_store_data),
    .mem_load_data  (mem_load_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_data        (tx_data),
    .misalign       (misalign),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t        tv[18];
  logic [31:0] sb_q[$];
  logic [7:0]  tx_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's access at the falling edge; the load result is
  // combinational and compared just after, well before the next rising edge.
  task automatic apply(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                       input bit c, input logic [31:0] e, input string name);
    @(negedge clk);
    mem_op = op; mem_addr = a; mem_store_data = d;
    if (c) sb_q.push_back(e);
    #2;
    if (c) chk(name, mem_load_data, sb_q.pop_front());
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 30;
    tx_ready = 1'b1;
    while (tx_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      mem_op = OP_NONE; mem_addr = '0; mem_store_data = '0;
      #2;
      if (tx_valid) chk(name, {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
      budget--;
    end
    if (tx_q.size() > 0) chk({name, "_timeout"}, tx_q.size(), 0);
    @(negedge clk);
    tx_ready = 1'b0;
    #2;
    chk({name, "_valid_low"}, {31'h0, tx_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = '{OP_SW,   32'h0000_0010, 32'hDDCC_BBAA, 1'b0, 32'h0,          "sw10"};
    tv[1]  = '{OP_NONE, 32'h0000_0010, 32'h0,         1'b1, 32'hDDCC_BBAA, "ld10"};
    tv[2]  = '{OP_NONE, 32'h0000_0011, 32'h0,         1'b1, 32'hAADD_CCBB, "ld11"};
    tv[3]  = '{OP_NONE, 32'h0000_0012, 32'h0,         1'b1, 32'hBBAA_DDCC, "ld12"};
    tv[4]  = '{OP_NONE, 32'h0000_0013, 32'h0,         1'b1, 32'hCCBB_AADD, "ld13"};
    tv[5]  = '{OP_SB,   32'h0000_0011, 32'h0000_0055, 1'b1, 32'hAADD_CCBB, "sb11_old"};
    tv[6]  = '{OP_NONE, 32'h0000_0010, 32'h0,         1'b1, 32'hDDCC_55AA, "after_sb"};
    tv[7]  = '{OP_SH,   32'h0000_0012, 32'h0000_1234, 1'b1, 32'h55AA_DDCC, "sh12_old"};
    tv[8]  = '{OP_NONE, 32'h0000_0010, 32'h0,         1'b1, 32'h1234_55AA, "after_sh"};
    tv[9]  = '{OP_NONE, 32'h0000_0013, 32'h0,         1'b1, 32'h3455_AA12, "half_wrap13"};
    tv[10] = '{OP_SW,   32'h0000_0012, 32'hFFFF_FFFF, 1'b1, 32'h55AA_1234, "sw_misal_old"};
    tv[11] = '{OP_NONE, 32'h0000_0010, 32'h0,         1'b1, 32'h1234_55AA, "misal_no_write"};
    tv[12] = '{OP_SW,   32'h2000_0010, 32'h0,         1'b1, 32'h0,          "unmapped_rd"};
    tv[13] = '{OP_NONE, 32'h0000_1010, 32'h0,         1'b1, 32'h1234_55AA, "alias"};
    tv[14] = '{OP_SW,   32'h0000_0014, 32'h1122_3344, 1'b0, 32'h0,          "sw14"};
    tv[15] = '{OP_SH,   32'h0000_0015, 32'h0000_BEEF, 1'b1, 32'h4411_2233, "sh15_misal"};
    tv[16] = '{OP_SB,   32'h0000_0017, 32'h0000_0099, 1'b1, 32'h2233_4411, "sb17_old"};
    tv[17] = '{OP_NONE, 32'h0000_0014, 32'h0,         1'b1, 32'h9922_3344, "after_sb17"};

    rst = 1'b1; tx_ready = 1'b0;
    mem_op = OP_NONE; mem_addr = '0; mem_store_data = '0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_tx_data",  {24'h0, tx_data},  32'h0);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);

    @(negedge clk);
    rst = 1'b0; mem_addr = A_CYC;
    #2;
    chk("cycle0", mem_load_data, 32'd0);
    apply(OP_NONE, A_CYC, '0, 1'b1, 32'd1, "cycle1");
    apply(OP_NONE, A_CYC, '0, 1'b1, 32'd2, "cycle2");

    foreach (tv[i]) apply(tv[i].op, tv[i].addr, tv[i].wdata, tv[i].chk, tv[i].exp, tv[i].name);
    apply(OP_NONE, 32'h0000_0010, '0, 1'b1, 32'h1234_55AA, "unmapped_drop");
    apply(OP_NONE, A_CONS,        '0, 1'b1, 32'h0,          "console_rd0");
    apply(OP_NONE, 32'hF000_000C, '0, 1'b1, 32'h0,          "mmio_hole");

    chk("misalign_set", {31'h0, misalign}, 32'h1);
    repeat (3) apply(OP_NONE, '0, '0, 1'b0, '0, "idle");
    chk("misalign_sticky", {31'h0, misalign}, 32'h1);
    apply(OP_NONE, A_STAT, '0, 1'b1, 32'h0000_000A, "status_misal");

    // rst pulse mid-run with a RAM store in the same cycle
    @(negedge clk);
    rst = 1'b1; mem_op = OP_SW; mem_addr = 32'h0000_0020; mem_store_data = 32'hCAFE_F00D;
    @(negedge clk);
    rst = 1'b0; mem_op = OP_NONE; mem_addr = A_CYC;
    #2;
    chk("cycle_after_rst", mem_load_data, 32'd0);
    chk("misalign_cleared", {31'h0, misalign}, 32'h0);
    apply(OP_NONE, 32'h0000_0020, '0, 1'b1, 32'hCAFE_F00D, "store_in_rst");
    apply(OP_NONE, A_STAT,        '0, 1'b1, 32'h0000_0002, "status_idle");
    apply(OP_NONE, A_CYC,         '0, 1'b1, 32'd3,         "cycle_after_rst3");

    @(negedge clk);
    force dut.r_cycle = 32'hFFFF_FFFF;
    #1;
    release dut.r_cycle;
    mem_op = OP_NONE; mem_addr = A_CYC;
    #1;
    chk("cycle_max", mem_load_data, 32'hFFFF_FFFF);
    apply(OP_NONE, A_CYC, '0, 1'b1, 32'd0, "cycle_wrap");

`ifdef RISCV_DMEM_CONSOLE_EN
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_q.push_back(8'(8'h41 + i));
      apply(OP_SB, A_CONS, 32'(8'h41 + i), 1'b0, '0, "push");
    end
    apply(OP_NONE, A_STAT, '0, 1'b1, 32'h0000_0085, "status_full_ovf");
    chk("overflow_set", {31'h0, overflow}, 32'h1);
    chk("head_41", {24'h0, tx_data}, 32'h41);
    drain("drain1");
    apply(OP_NONE, A_STAT, '0, 1'b1, 32'h0000_0006, "status_empty_ovf");

    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tx_q.push_back(8'(8'h61 + i));
      apply(OP_SB, A_CONS, 32'(8'h61 + i), 1'b0, '0, "push2");
    end
    @(negedge clk);
    tx_ready = 1'b1; mem_op = OP_SW; mem_addr = A_CONS; mem_store_data = 32'h0000_005A;
    tx_q.push_back(8'h5A);
    #2;
    chk("full_push_pop_head", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
    @(negedge clk);
    tx_ready = 1'b0;
    apply(OP_NONE, A_STAT, '0, 1'b1, 32'h0000_0081, "status_full_noovf");
    chk("no_overflow", {31'h0, overflow}, 32'h0);
    drain("drain2");

    @(negedge clk);
    tx_ready = 1'b1; mem_op = OP_SB; mem_addr = A_CONS; mem_store_data = 32'h0000_007E;
    #2;
    chk("empty_push_pop_valid", {31'h0, tx_valid}, 32'h0);
    @(negedge clk);
    mem_op = OP_NONE; mem_addr = '0;
    #2;
    chk("passthru_valid", {31'h0, tx_valid}, 32'h1);
    chk("passthru_data",  {24'h0, tx_data},  32'h7E);
    @(negedge clk);
    tx_ready = 1'b0;
    #2;
    chk("passthru_popped", {31'h0, tx_valid}, 32'h0);
`else
    apply(OP_SB, A_CONS, 32'h0000_0041, 1'b0, '0, "cons_store");
    apply(OP_NONE, A_STAT, '0, 1'b1, 32'h0000_0002, "status_noconsole");
    chk("noconsole_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("noconsole_tx_data",  {24'h0, tx_data},  32'h0);
    chk("noconsole_overflow", {31'h0, overflow}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
